// File: rtl/conv_via_tiling_mul_pkg.sv
// Shared constants and helpers for the pipelined mixed-sign tiling multiplier.
package conv_via_tiling_mul_pkg;

    localparam int MAX_STAGE = 8;
    // Widest product the overflow helper handles; products are sign-extended to this width.
    localparam int MAX_FW    = 128;

    function automatic int full_width(input int w0, input int w1);
        return w0 + w1 + 2;
    endfunction

    // Set when any bit at or above dout_w-1 differs from the sign, i.e. the
    // signed value does not survive truncation to dout_w bits.
    function automatic logic ovf_check(input logic [MAX_FW-1:0] p, input int dout_w);
        logic ovf;
        ovf = 1'b0;
        for (int i = 0; i < MAX_FW; i++) begin
            if (i >= dout_w - 1 && p[i] != p[MAX_FW-1]) begin
                ovf = 1'b1;
            end
        end
        return ovf;
    endfunction

endpackage

// File: rtl/conv_via_tiling_mul_slice.sv
// One valid/ready register slice: it loads from upstream whenever it is empty
// or its own beat is leaving this cycle, which collapses bubbles.
module conv_via_tiling_mul_slice #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_ce,
    input  logic         i_valid,
    input  logic [W-1:0] i_data,
    output logic         o_ready,
    output logic         o_valid,
    output logic [W-1:0] o_data,
    input  logic         i_ready
);

    logic         r_valid;
    logic [W-1:0] r_data;

    assign o_ready = ~r_valid | i_ready;
    assign o_valid = r_valid;
    assign o_data  = r_data;

    // NOTE: the data register is cleared by reset as well, so dout reads 0 after reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_ce && o_ready) begin
            r_valid <= i_valid;
            r_data  <= i_data;
        end
    end

endmodule

// File: rtl/conv_via_tiling_mul_pipe.sv
// Pipelined mixed-sign multiplier: slice 0 holds extended operands, the product
// and overflow flag are formed after it, and the remaining slices only register.
module conv_via_tiling_mul_pipe
    import conv_via_tiling_mul_pkg::*;
#(
    parameter int ID         = 1,
    parameter int NUM_STAGE  = 3,
    parameter int din0_WIDTH = 32,
    parameter int din1_WIDTH = 34,
    parameter int dout_WIDTH = 65
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  ce,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    input  logic                  din0_signed,
    input  logic                  din1_signed,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [dout_WIDTH-1:0] dout,
    output logic                  out_ovf
);

    localparam int FW = full_width(din0_WIDTH, din1_WIDTH);
    localparam int AW = din0_WIDTH + 1;
    localparam int BW = din1_WIDTH + 1;
    localparam int RW = dout_WIDTH + 1;

    logic [NUM_STAGE:0]       w_v;
    logic [NUM_STAGE:0]       w_rdy;
    logic [RW-1:0]            w_q [NUM_STAGE];
    logic signed [AW-1:0]     w_ext_a;
    logic signed [BW-1:0]     w_ext_b;
    logic signed [AW-1:0]     w_mul_a;
    logic signed [BW-1:0]     w_mul_b;
    logic signed [FW-1:0]     w_p;
    logic signed [MAX_FW-1:0] w_p_ext;
    logic [RW-1:0]            w_res;

    assign w_ext_a = {din0_signed & din0[din0_WIDTH-1], din0};
    assign w_ext_b = {din1_signed & din1[din1_WIDTH-1], din1};

    // Both operands are signed after extension, so one signed multiply covers all four modes.
    assign w_p     = FW'(w_mul_a) * FW'(w_mul_b);
    assign w_p_ext = MAX_FW'(w_p);
    assign w_res   = {ovf_check(w_p_ext, dout_WIDTH), w_p_ext[dout_WIDTH-1:0]};

    assign w_v[0]         = in_valid;
    assign w_rdy[NUM_STAGE] = out_ready;

    for (genvar k = 0; k < NUM_STAGE; k++) begin : g_stage
        if (k == 0 && NUM_STAGE > 1) begin : g_opnd
            logic [AW+BW-1:0] w_op;
            conv_via_tiling_mul_slice #(.W(AW + BW)) u_slice (
                .i_clk   (ap_clk),
                .i_rst_n (ap_rst_n),
                .i_ce    (ce),
                .i_valid (w_v[k]),
                .i_data  ({w_ext_a, w_ext_b}),
                .o_ready (w_rdy[k]),
                .o_valid (w_v[k+1]),
                .o_data  (w_op),
                .i_ready (w_rdy[k+1])
            );
            assign w_mul_a = w_op[AW+BW-1:BW];
            assign w_mul_b = w_op[BW-1:0];
            assign w_q[k]  = '0;
        end else begin : g_res
            logic [RW-1:0] w_d;
            if (k <= 1) begin : g_from_mul
                assign w_d = w_res;
            end else begin : g_from_prev
                assign w_d = w_q[k-1];
            end
            conv_via_tiling_mul_slice #(.W(RW)) u_slice (
                .i_clk   (ap_clk),
                .i_rst_n (ap_rst_n),
                .i_ce    (ce),
                .i_valid (w_v[k]),
                .i_data  (w_d),
                .o_ready (w_rdy[k]),
                .o_valid (w_v[k+1]),
                .o_data  (w_q[k]),
                .i_ready (w_rdy[k+1])
            );
        end
    end

    // A single-stage pipe multiplies straight from the ports.
    if (NUM_STAGE == 1) begin : g_comb_mul
        assign w_mul_a = w_ext_a;
        assign w_mul_b = w_ext_b;
    end

    assign in_ready  = ce & ap_rst_n & w_rdy[0];
    assign out_valid = w_v[NUM_STAGE] & ap_rst_n;
    assign dout      = w_q[NUM_STAGE-1][dout_WIDTH-1:0];
    assign out_ovf   = w_q[NUM_STAGE-1][dout_WIDTH];

endmodule

// File: tb/tb_conv_via_tiling_mul_pipe.sv
// Randomised scoreboard bench for conv_via_tiling_mul_pipe with an
// integer-arithmetic reference model.
module tb_conv_via_tiling_mul_pipe;

    localparam int N = 3;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n;
    logic        ce;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] din0;
    logic [33:0] din1;
    logic        din0_signed;
    logic        din1_signed;
    logic        out_valid;
    logic        out_ready;
    logic [64:0] dout;
    logic        out_ovf;

    conv_via_tiling_mul_pipe #(
        .ID(1), .NUM_STAGE(N), .din0_WIDTH(32), .din1_WIDTH(34), .dout_WIDTH(65)
    ) dut (
        .ap_clk      (ap_clk),
        .ap_rst_n    (ap_rst_n),
        .ce          (ce),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .din0        (din0),
        .din1        (din1),
        .din0_signed (din0_signed),
        .din1_signed (din1_signed),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .dout        (dout),
        .out_ovf     (out_ovf)
    );

    always #5 ap_clk = ~ap_clk;

    typedef struct {
        logic [64:0] d;
        logic        o;
        int          acc;
        int          lat;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   lat_expect = 0;
    int   n_out    = 0;
    bit   rand_done = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: operands as mathematical integers, product range-checked against 65-bit signed.
    function automatic void model(input logic [31:0] a, input logic [33:0] b,
                                  input logic sa, input logic sb,
                                  output logic [64:0] d, output logic o);
        logic signed [127:0] va, vb, p, lim;
        va  = sa ? {{96{a[31]}}, a} : {96'b0, a};
        vb  = sb ? {{94{b[33]}}, b} : {94'b0, b};
        p   = va * vb;
        lim = 128'sd1 <<< 64;
        d   = p[64:0];
        o   = (p < -lim) || (p >= lim);
    endfunction

    always @(posedge ap_clk) cyc <= cyc + 1;

    // Scoreboard: pushes on accept, pops and compares on each consumed result.
    logic        prev_stall = 1'b0;
    logic        prev_rst_n = 1'b1;
    logic [64:0] prev_dout;
    logic        prev_ovf;
    always @(negedge ap_clk) begin : scoreboard
        exp_t e;
        logic exp_rdy;
        exp_rdy = ce && ap_rst_n && (sb_q.size() < N || out_ready);
        check("in_ready", in_ready, exp_rdy);
        if (sb_q.size() == 0) check("spurious_out_valid", out_valid, 1'b0);
        if (!ap_rst_n) begin
            check("rst_out_valid", out_valid, 1'b0);
            if (!prev_rst_n) begin
                check("rst_dout", dout, 65'd0);
                check("rst_ovf", out_ovf, 1'b0);
            end
            sb_q.delete();
        end else begin
            if (prev_stall) begin
                check("stall_valid", out_valid, 1'b1);
                check("stall_dout", dout, prev_dout);
                check("stall_ovf", out_ovf, prev_ovf);
            end
            if (out_valid && out_ready && ce && sb_q.size() > 0) begin
                e = sb_q.pop_front();
                n_out++;
                check("dout", dout, e.d);
                check("out_ovf", out_ovf, e.o);
                if (e.lat != 0) check("latency", cyc - e.acc, e.lat);
            end
            if (in_valid && in_ready) begin
                model(din0, din1, din0_signed, din1_signed, e.d, e.o);
                e.acc = cyc;
                e.lat = lat_expect;
                sb_q.push_back(e);
            end
        end
        prev_stall = ap_rst_n && out_valid && !(out_ready && ce);
        prev_dout  = dout;
        prev_ovf   = out_ovf;
        prev_rst_n = ap_rst_n;
    end

    task automatic send(input logic [31:0] a, input logic [33:0] b, input logic sa, input logic sb);
        int t;
        t = 0;
        in_valid = 1'b1;
        din0 = a; din1 = b; din0_signed = sa; din1_signed = sb;
        do begin
            @(negedge ap_clk);
            t++;
        end while (!in_ready && t < 200);
        if (!in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles", t);
        end
        @(posedge ap_clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (sb_q.size() != 0 && t < 100) begin
            @(posedge ap_clk);
            t++;
        end
        #1;
        check("drain_empty", sb_q.size(), 0);
    endtask

    initial begin
        ap_rst_n = 1'b0; ce = 1'b1; out_ready = 1'b1;
        in_valid = 1'b1; din0 = 32'd7; din1 = 34'd9; din0_signed = 1'b0; din1_signed = 1'b0;
        repeat (3) @(posedge ap_clk);
        #1;
        in_valid = 1'b0;
        ap_rst_n = 1'b1;
        repeat (5) @(posedge ap_clk);
        #1;
        check("no_output_after_reset", n_out, 0);

        // Directed arithmetic cases with latency checked.
        lat_expect = N;
        send(32'hFFFF_FFFD, 34'd5, 1'b1, 1'b0);
        send(32'hFFFF_FFFD, 34'd5, 1'b0, 1'b0);
        send(32'h8000_0000, 34'h3_FFFF_FFFF, 1'b1, 1'b0);
        send(32'hFFFF_FFFF, 34'h3_FFFF_FFFF, 1'b1, 1'b1);
        wait_drain();

        // Backpressure: 8 beats back-to-back with a 6-cycle stall.
        lat_expect = 0;
        fork
            begin
                for (int i = 1; i <= 8; i++) send(32'(i), 34'd3, 1'b0, 1'b0);
            end
            begin
                repeat (4) @(posedge ap_clk);
                #1 out_ready = 1'b0;
                repeat (6) @(posedge ap_clk);
                #1 out_ready = 1'b1;
            end
        join
        wait_drain();

        // Clock-enable gap: two beats in flight frozen for two cycles.
        lat_expect = N + 2;
        send(32'd11, 34'd13, 1'b0, 1'b0);
        send(32'hFFFF_FFF0, 34'd17, 1'b1, 1'b1);
        ce = 1'b0;
        repeat (2) @(posedge ap_clk);
        #1 ce = 1'b1;
        wait_drain();

        // Reset with two beats in flight; nothing stale may emerge.
        lat_expect = 0;
        send(32'd21, 34'd2, 1'b0, 1'b0);
        send(32'd22, 34'd2, 1'b0, 1'b0);
        ap_rst_n = 1'b0;
        @(posedge ap_clk);
        #1 ap_rst_n = 1'b1;
        repeat (6) @(posedge ap_clk);
        #1;
        lat_expect = N;
        send(32'd5, 34'd6, 1'b1, 1'b1);
        wait_drain();

        // Randomised traffic with random backpressure and clock-enable drops.
        lat_expect = 0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    logic [31:0] a;
                    logic [33:0] b;
                    case ($urandom_range(0, 5))
                        0: a = 32'h8000_0000;
                        1: a = 32'hFFFF_FFFF;
                        default: a = $urandom();
                    endcase
                    case ($urandom_range(0, 5))
                        0: b = 34'h2_0000_0000;
                        1: b = 34'h3_FFFF_FFFF;
                        default: b = {2'($urandom_range(0, 3)), 32'($urandom())};
                    endcase
                    send(a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                    if ($urandom_range(0, 3) == 0) begin
                        repeat ($urandom_range(1, 3)) @(posedge ap_clk);
                        #1;
                    end
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge ap_clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                    ce        = ($urandom_range(0, 9) != 0);
                end
                ce = 1'b1;
                out_ready = 1'b1;
            end
        join
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/conv_via_tiling_mul_pipe.md
Name: conv_via_tiling_mul_pipe

Overview:
- Parametrised, pipelined successor to the conv_via_tiling combinational mixed-sign multiplier.
- Per-transaction signedness select for each operand.
- valid/ready handshake with per-stage bubble collapsing, clock enable, and a truncation-overflow flag.
- Sits between the tiling address/weight datapath and the accumulator; NUM_STAGE sets the timing/latency trade-off.

Parameters:
- ID, 1, instance tag; no functional effect.
- NUM_STAGE, 3, pipeline depth and latency in cycles; legal range 1..8.
- din0_WIDTH, 32, operand A width.
- din1_WIDTH, 34, operand B width.
- dout_WIDTH, 65, result width.

Ports:
- ap_clk  in  1  clock; all state changes on the rising edge.
- ap_rst_n  in  1  synchronous active-low reset.
- ce  in  1  clock enable; 0 freezes all state.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block accepts a beat this cycle.
- din0  in  din0_WIDTH  operand A.
- din1  in  din1_WIDTH  operand B.
- din0_signed  in  1  1: A is two's complement; 0: A is unsigned.
- din1_signed  in  1  same, for B.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- dout  out  dout_WIDTH  product.
- out_ovf  out  1  truncation to dout_WIDTH lost information.

Behaviour:
- Reset:
  - While ap_rst_n=0 at a rising edge, all stage valid bits, data registers, dout and out_ovf clear to 0.
  - in_ready=0 and out_valid=0 while ap_rst_n=0.
  - Reset mid-stream discards all in-flight beats; nothing from before reset is ever emitted.
- Pipeline: NUM_STAGE register slices, each with valid bit v[k]; slice NUM_STAGE-1 drives the outputs.
  - rdy[k] = ~v[k] | rdy[k+1], with rdy[NUM_STAGE] = out_ready.
  - in_ready = ce & ap_rst_n & rdy[0].
  - A slice loads from upstream when ce & rdy[k]; its valid bit takes upstream valid.
- Accept: a beat is taken when in_valid & in_ready.
  - With out_ready held high, out_valid rises exactly NUM_STAGE cycles after acceptance.
  - Throughput is one beat per cycle.
- Backpressure:
  - out_ready=0 with out_valid=1: dout and out_ovf hold stable, and bubbles upstream collapse.
  - Capacity is NUM_STAGE beats; in_ready falls only when every slice is full.
  - Beats are emitted in order, with no loss and no duplication.
- ce=0: no register updates and in_ready=0; out_valid, dout and out_ovf hold. A result is not consumed while ce=0.
- Arithmetic:
  - Slice 0 registers each operand extended to width+1 bits: sign-extended if its signed flag is 1, zero-extended otherwise.
  - Product P = signed(A') * signed(B'), width FW = din0_WIDTH + din1_WIDTH + 2, formed between slice 0 and slice 1. With NUM_STAGE=1 it is formed combinationally before the single slice.
  - Remaining slices only register.
  - dout = P[dout_WIDTH-1:0] if dout_WIDTH <= FW, otherwise P sign-extended.
- Overflow: out_ovf = 1 iff P[FW-1:dout_WIDTH-1] is not all-equal (signed-range loss); always 0 when dout_WIDTH >= FW. It is computed alongside the product and travels with its beat.
- Signedness flags are sampled with the operands; changing them between beats affects only subsequent beats.
- Simultaneous output pop and input push on a full pipe: both occur in the same cycle, and occupancy is unchanged.

Decomposition:
- Package conv_via_tiling_mul_pkg holds:
  - localparam function full_width(w0,w1) = w0+w1+2.
  - Function ovf_check(P, dout_w).
  - Constant MAX_STAGE=8.
- Sub-module conv_via_tiling_mul_slice: one valid/ready register slice with data width parameter, ce and sync active-low reset. It is instantiated NUM_STAGE times via generate; product and overflow logic stay in the top.

Test Plan:
- Reset with in_valid=1, din0=7, din1=9 held 3 cycles at ap_rst_n=0 -> in_ready=0, out_valid=0, dout=0, out_ovf=0 throughout, and no output appears after release.
- din0=32'hFFFFFFFD, din0_signed=1, din1=5, din1_signed=0, out_ready=1 -> exactly 3 cycles later out_valid=1, dout=65'h1_FFFF_FFFF_FFFF_FFF1 (-15), out_ovf=0.
- Same operands with din0_signed=0 -> dout=65'h0_0000_0004_FFFF_FFF1 (21474836465), out_ovf=0.
- Overflow case -> dout=65'h0_0000_0000_8000_0000, out_ovf=1.
  - Stimulus: din0=32'h80000000 signed, din1=34'h3_FFFF_FFFF unsigned.
  - P = -2^65 + 2^31 does not fit in 65 bits.
- Backpressure: stream 8 beats (din0=1..8, din1=3) back-to-back, with out_ready=0 from cycle 4 to cycle 9.
  - in_ready falls after 3 beats are buffered.
  - Outputs are 3,6,...,24 in order, each exactly once.
  - dout is stable while stalled.
- ce=0 for 2 cycles mid-stream, then ap_rst_n=0 for 1 cycle with 2 beats in flight.
  - The ce gap delays all outputs by exactly 2 cycles.
  - After reset no stale beat emerges, and a beat accepted after reset completes in 3 cycles.
